// File: rtl/pattern_match_tracker.sv
// Debounces per-sample pattern-match flags into a LOCK/SEARCH decision with hysteresis,
// plus match statistics. Define PATTERN_MATCH_TRACKER_STAMP_EN to add the lock sample stamp.
module pattern_match_tracker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID_IN,
    input  logic             MATCH_IN,
    input  logic             CLR,
    output logic             LOCKED,
    output logic             LOCK_PULSE,
    output logic             LOSS_PULSE,
    output logic [7:0]       RUN_LEN,
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
    output logic [31:0]      LOCK_STAMP,
`endif
    output logic [CNT_W-1:0] MATCH_TOTAL
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

    localparam logic [7:0]       LOCK_C    = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_C  = 8'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] TOTAL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TOTAL_ONE = CNT_W'(1'b1);

    state_t           state_r, state_nxt_s;
    logic [7:0]       run_r, run_nxt_s, run_inc_s;
    logic [7:0]       miss_r, miss_nxt_s;
    logic [CNT_W-1:0] total_r, total_nxt_s;
    logic             locked_r, locked_nxt_s;
    logic             lock_pulse_r, lock_pulse_nxt_s;
    logic             loss_pulse_r, loss_pulse_nxt_s;
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
    logic [31:0]      sample_idx_r, sample_idx_nxt_s;
    logic [31:0]      lock_stamp_r, lock_stamp_nxt_s;
`endif

    // Next-state, statistics and pulse decode for one sample
    always_comb begin
        state_nxt_s      = state_r;
        run_nxt_s        = run_r;
        miss_nxt_s       = miss_r;
        total_nxt_s      = total_r;
        lock_pulse_nxt_s = 1'b0;
        loss_pulse_nxt_s = 1'b0;
        run_inc_s        = (run_r == 8'hFF) ? run_r : run_r + 8'd1;

        if (VALID_IN) begin
            if (MATCH_IN) begin
                run_nxt_s   = run_inc_s;
                total_nxt_s = (total_r == TOTAL_MAX) ? total_r : total_r + TOTAL_ONE;
            end else begin
                run_nxt_s   = 8'd0;
            end

            case (state_r)
                SEARCH: begin
                    if (MATCH_IN && (run_inc_s >= LOCK_C)) begin
                        state_nxt_s      = LOCK;
                        lock_pulse_nxt_s = 1'b1;
                        miss_nxt_s       = 8'd0;
                    end else begin
                        state_nxt_s      = SEARCH;
                    end
                end
                LOCK: begin
                    if (MATCH_IN) begin
                        miss_nxt_s       = 8'd0;
                    end else if (miss_r == (UNLOCK_C - 8'd1)) begin
                        // Enough consecutive misses: fall back to searching
                        state_nxt_s      = SEARCH;
                        loss_pulse_nxt_s = 1'b1;
                        miss_nxt_s       = 8'd0;
                    end else begin
                        miss_nxt_s       = miss_r + 8'd1;
                    end
                end
                default: begin
                    state_nxt_s = SEARCH;
                    miss_nxt_s  = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        locked_nxt_s = (state_nxt_s == LOCK);
    end

`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
    // Sample index advance and lock stamp capture
    always_comb begin
        sample_idx_nxt_s = sample_idx_r;
        lock_stamp_nxt_s = lock_stamp_r;
        if (VALID_IN) begin
            sample_idx_nxt_s = sample_idx_r + 32'd1;
        end else begin
            sample_idx_nxt_s = sample_idx_r;
        end
        if (lock_pulse_nxt_s) begin
            lock_stamp_nxt_s = sample_idx_r;
        end else begin
            lock_stamp_nxt_s = lock_stamp_r;
        end
    end

    // Stamp registers; CLR clears like reset and discards the concurrent sample
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            sample_idx_r <= 32'd0;
            lock_stamp_r <= 32'd0;
        end else begin
            sample_idx_r <= sample_idx_nxt_s;
            lock_stamp_r <= lock_stamp_nxt_s;
        end
    end

    assign LOCK_STAMP = lock_stamp_r;
`endif

    // State and output registers; CLR clears like reset and discards the concurrent sample
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state_r      <= SEARCH;
            run_r        <= 8'd0;
            miss_r       <= 8'd0;
            total_r      <= {CNT_W{1'b0}};
            locked_r     <= 1'b0;
            lock_pulse_r <= 1'b0;
            loss_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            run_r        <= run_nxt_s;
            miss_r       <= miss_nxt_s;
            total_r      <= total_nxt_s;
            locked_r     <= locked_nxt_s;
            lock_pulse_r <= lock_pulse_nxt_s;
            loss_pulse_r <= loss_pulse_nxt_s;
        end
    end

    assign LOCKED      = locked_r;
    assign LOCK_PULSE  = lock_pulse_r;
    assign LOSS_PULSE  = loss_pulse_r;
    assign RUN_LEN     = run_r;
    assign MATCH_TOTAL = total_r;

    pattern_match_tracker_chk #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .CNT_W      (CNT_W)
    ) u_chk (
        .CLK        (CLK),
        .RST        (RST),
        .lock_pulse (lock_pulse_r),
        .loss_pulse (loss_pulse_r)
    );

endmodule

// Simulation checker: parameter legality and pulse exclusivity.
module pattern_match_tracker_chk #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 16
) (
    input logic CLK,
    input logic RST,
    input logic lock_pulse,
    input logic loss_pulse
);

    // Per-cycle legality checks
    always @(posedge CLK) begin
        assert ((LOCK_CNT >= 1) && (LOCK_CNT <= 255))
            else $error("pattern_match_tracker: LOCK_CNT %0d outside 1..255", LOCK_CNT);
        assert ((UNLOCK_CNT >= 1) && (UNLOCK_CNT <= 255))
            else $error("pattern_match_tracker: UNLOCK_CNT %0d outside 1..255", UNLOCK_CNT);
        assert (CNT_W >= 1)
            else $error("pattern_match_tracker: CNT_W %0d must be positive", CNT_W);
        if (!RST) begin
            assert (!(lock_pulse && loss_pulse))
                else $error("pattern_match_tracker: lock and loss pulses together");
        end
    end

endmodule

// File: tb/tb_pattern_match_tracker.sv
// Directed bench for pattern_match_tracker: lock/hysteresis, gaps, clear, reset and saturation.
module tb_pattern_match_tracker;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic        va, ma, vb, mb;
    logic        a_locked, a_lp, a_sp;
    logic [7:0]  a_run;
    logic [15:0] a_tot;
    logic        b_locked, b_lp, b_sp;
    logic [7:0]  b_run;
    logic [3:0]  b_tot;
    logic        c_locked, c_lp, c_sp;
    logic [7:0]  c_run;
    logic [7:0]  c_tot;
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
    logic [31:0] a_stamp, b_stamp, c_stamp;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_match_tracker #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(16)) dut_a (
        .CLK(clk), .RST(rst), .VALID_IN(va), .MATCH_IN(ma), .CLR(clr),
        .LOCKED(a_locked), .LOCK_PULSE(a_lp), .LOSS_PULSE(a_sp), .RUN_LEN(a_run),
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        .LOCK_STAMP(a_stamp),
`endif
        .MATCH_TOTAL(a_tot));

    pattern_match_tracker #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(4)) dut_b (
        .CLK(clk), .RST(rst), .VALID_IN(vb), .MATCH_IN(mb), .CLR(clr),
        .LOCKED(b_locked), .LOCK_PULSE(b_lp), .LOSS_PULSE(b_sp), .RUN_LEN(b_run),
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        .LOCK_STAMP(b_stamp),
`endif
        .MATCH_TOTAL(b_tot));

    pattern_match_tracker #(.LOCK_CNT(1), .UNLOCK_CNT(1), .CNT_W(8)) dut_c (
        .CLK(clk), .RST(rst), .VALID_IN(vb), .MATCH_IN(mb), .CLR(clr),
        .LOCKED(c_locked), .LOCK_PULSE(c_lp), .LOSS_PULSE(c_sp), .RUN_LEN(c_run),
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        .LOCK_STAMP(c_stamp),
`endif
        .MATCH_TOTAL(c_tot));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs on dut_a; outputs are sampled 1 time unit after the edge
    task automatic step_a(input logic v, input logic m);
        va = v;
        ma = m;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic m);
        vb = v;
        mb = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_run [8];
        exp_run = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        rst = 1'b1; clr = 1'b0; va = 1'b0; ma = 1'b0; vb = 1'b0; mb = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_locked", {31'd0, a_locked}, 32'd0);
        check("rst_pulses", {30'd0, a_lp, a_sp}, 32'd0);
        check("rst_run", {24'd0, a_run}, 32'd0);
        check("rst_total", {16'd0, a_tot}, 32'd0);

        // Matches without VALID_IN must be ignored
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b1);
        check("hold_run", {24'd0, a_run}, 32'd0);
        check("hold_total", {16'd0, a_tot}, 32'd0);
        check("hold_locked", {31'd0, a_locked}, 32'd0);

        // Lock acquisition: 1,1,1,0,1,1,1,1
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, (i == 3) ? 1'b0 : 1'b1);
            check($sformatf("acq_run%0d", i), {24'd0, a_run}, {24'd0, exp_run[i]});
            if (i < 7) check($sformatf("acq_nolock%0d", i), {30'd0, a_locked, a_lp}, 32'd0);
        end
        check("acq_pulse", {31'd0, a_lp}, 32'd1);
        check("acq_locked", {31'd0, a_locked}, 32'd1);
        check("acq_total", {16'd0, a_tot}, 32'd7);
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        check("acq_stamp", a_stamp, 32'd7);
`endif
        step_a(1'b0, 1'b0);
        check("acq_pulse_end", {31'd0, a_lp}, 32'd0);
        check("acq_locked_hold", {31'd0, a_locked}, 32'd1);

        // Hysteresis: isolated misses keep lock, two in a row drop it
        step_a(1'b1, 1'b0); check("hy_miss1_run", {24'd0, a_run}, 32'd0);
        step_a(1'b1, 1'b1); check("hy_match1_run", {24'd0, a_run}, 32'd1);
        step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b1);
        check("hy_locked", {31'd0, a_locked}, 32'd1);
        check("hy_total", {16'd0, a_tot}, 32'd9);
        step_a(1'b1, 1'b0);
        check("hy_first_miss", {30'd0, a_locked, a_sp}, 32'd2);
        step_a(1'b1, 1'b0);
        check("hy_loss_pulse", {31'd0, a_sp}, 32'd1);
        check("hy_unlocked", {31'd0, a_locked}, 32'd0);
        check("hy_run", {24'd0, a_run}, 32'd0);
        check("hy_no_lockpulse", {31'd0, a_lp}, 32'd0);
        step_a(1'b0, 1'b0);
        check("hy_loss_end", {31'd0, a_sp}, 32'd0);

        // Gapped valids: four matches, three idle cycles between each
        for (int k = 0; k < 4; k++) begin
            step_a(1'b1, 1'b1);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) step_a(1'b0, 1'b1);
                check($sformatf("gap_run%0d", k), {24'd0, a_run}, k + 1);
                check($sformatf("gap_total%0d", k), {16'd0, a_tot}, 10 + k);
                check($sformatf("gap_nolock%0d", k), {30'd0, a_locked, a_lp}, 32'd0);
            end
        end
        check("gap_lock", {30'd0, a_locked, a_lp}, 32'd3);
        check("gap_total", {16'd0, a_tot}, 32'd13);
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        check("gap_stamp", a_stamp, 32'd17);
`endif

        // CLR beats a concurrent valid match
        clr = 1'b1;
        step_a(1'b1, 1'b1);
        clr = 1'b0;
        check("clr_locked", {31'd0, a_locked}, 32'd0);
        check("clr_total", {16'd0, a_tot}, 32'd0);
        check("clr_run", {24'd0, a_run}, 32'd0);
        check("clr_pulses", {30'd0, a_lp, a_sp}, 32'd0);
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        check("clr_stamp", a_stamp, 32'd0);
`endif

        // Relock, then reset mid-lock: no loss pulse
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b1);
        check("relock", {30'd0, a_locked, a_lp}, 32'd3);
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
        check("relock_stamp", a_stamp, 32'd3);
`endif
        rst = 1'b1;
        step_a(1'b1, 1'b1);
        rst = 1'b0;
        check("rst_mid_lock", {29'd0, a_locked, a_lp, a_sp}, 32'd0);
        check("rst_mid_total", {16'd0, a_tot}, 32'd0);

        // RUN_LEN saturates at 255 while matches continue
        for (int i = 0; i < 300; i++) step_a(1'b1, 1'b1);
        check("runsat_run", {24'd0, a_run}, 32'd255);
        check("runsat_total", {16'd0, a_tot}, 32'd300);
        check("runsat_locked", {31'd0, a_locked}, 32'd1);
        step_a(1'b0, 1'b0);

        // Narrow counter saturation (dut_b) and LOCK_CNT=UNLOCK_CNT=1 (dut_c)
        step_b(1'b1, 1'b1);
        check("c_first_lock", {30'd0, c_locked, c_lp}, 32'd3);
        check("b_first_nolock", {31'd0, b_locked}, 32'd0);
        for (int i = 1; i < 20; i++) begin
            step_b(1'b1, 1'b1);
            if (i == 3) begin
                check("b_lock4", {30'd0, b_locked, b_lp}, 32'd3);
`ifdef PATTERN_MATCH_TRACKER_STAMP_EN
                check("b_stamp", b_stamp, 32'd3);
`endif
            end
            if (i == 14) check("b_total15", {28'd0, b_tot}, 32'd15);
            if (i == 15) check("b_total16", {28'd0, b_tot}, 32'd15);
        end
        check("b_total_sat", {28'd0, b_tot}, 32'd15);
        check("b_locked", {31'd0, b_locked}, 32'd1);
        check("b_run", {24'd0, b_run}, 32'd20);
        check("c_total", {24'd0, c_tot}, 32'd20);
        step_b(1'b1, 1'b0);
        check("c_loss1", {30'd0, c_locked, c_sp}, 32'd1);
        check("b_keep", {30'd0, b_locked, b_sp}, 32'd2);
        check("b_total_miss", {28'd0, b_tot}, 32'd15);
        step_b(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
